// File: rtl/timer_dev_pkg.sv
// Shared definitions for timer_dev: register offsets, CTRL bit positions,
// mode codes and the counter FSM state encoding.
package timer_dev_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_MODE_MSB = 2;
    localparam int CTRL_IM_BIT   = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_RELOAD  = 2'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_e;

endpackage

// File: rtl/timer_dev.sv
// Memory-mapped 32-bit down-counting timer with interrupt (CTRL/PRESET/COUNT).
// Define TIMER_DEV_AUTORELOAD_EN to enable Mode=1 auto-reload; otherwise one-shot only.
module timer_dev
    import timer_dev_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  Addr,
    input  logic [31:0] WD,
    input  logic        We,
    output logic [31:0] RD,
    output logic        IRQ
);

    state_e      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        pending_q, pending_d;
    logic        reload_s;
    logic [1:0]  mode_wr_s;

`ifdef TIMER_DEV_AUTORELOAD_EN
    assign reload_s  = (ctrl_q[CTRL_MODE_MSB:CTRL_MODE_LSB] == MODE_RELOAD);
    assign mode_wr_s = WD[CTRL_MODE_MSB:CTRL_MODE_LSB];
`else
    assign reload_s  = 1'b0;
    assign mode_wr_s = MODE_ONESHOT;
`endif

    // State and register flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ctrl_q    <= 4'd0;
            preset_q  <= 32'd0;
            count_q   <= 32'd0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            preset_q  <= preset_d;
            count_q   <= count_d;
            pending_q <= pending_d;
        end
    end

    // Counter FSM next state, then bus writes which take priority over it
    always_comb begin
        state_d   = state_q;
        ctrl_d    = ctrl_q;
        preset_d  = preset_q;
        count_d   = count_q;
        pending_d = pending_q;

        case (state_q)
            ST_IDLE: begin
                if (ctrl_q[CTRL_EN_BIT]) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_q[CTRL_EN_BIT]) begin
                    state_d = ST_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    // PRESET of 0 lands here straight after LOAD, same as PRESET of 1
                    count_d   = 32'd0;
                    pending_d = 1'b1;
                    state_d   = ST_INT;
                end
            end
            ST_INT: begin
                if (reload_s) begin
                    pending_d = 1'b0;
                    state_d   = ST_LOAD;
                end else begin
                    ctrl_d[CTRL_EN_BIT] = 1'b0;
                    state_d             = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (We) begin
            case (Addr)
                ADDR_CTRL: begin
                    ctrl_d    = {WD[CTRL_IM_BIT], mode_wr_s, WD[CTRL_EN_BIT]};
                    pending_d = 1'b0;
                end
                ADDR_PRESET: begin
                    preset_d  = WD;
                    pending_d = 1'b0;
                end
                default: begin
                    ctrl_d = ctrl_d;
                end
            endcase
        end else begin
            ctrl_d = ctrl_d;
        end
    end

    // Zero-latency read mux
    always_comb begin
        case (Addr)
            ADDR_CTRL:   RD = {28'd0, ctrl_q};
            ADDR_PRESET: RD = preset_q;
            ADDR_COUNT:  RD = count_q;
            default:     RD = 32'd0;
        endcase
    end

    assign IRQ = ctrl_q[CTRL_IM_BIT] & pending_q;

endmodule

// File: tb/tb_timer_dev.sv
// Self-checking bench for timer_dev: expectations are queued with a target
// edge number when stimulus is applied and compared when that edge is reached.
module tb_timer_dev;

    logic        clk;
    logic        rst_n;
    logic [1:0]  Addr;
    logic [31:0] WD;
    logic        We;
    logic [31:0] RD;
    logic        IRQ;

    timer_dev dut (
        .clk   (clk),
        .rst_n (rst_n),
        .Addr  (Addr),
        .WD    (WD),
        .We    (We),
        .RD    (RD),
        .IRQ   (IRQ)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    localparam logic [2:0] SEL_CTRL   = 3'd0;
    localparam logic [2:0] SEL_PRESET = 3'd1;
    localparam logic [2:0] SEL_COUNT  = 3'd2;
    localparam logic [2:0] SEL_RSVD   = 3'd3;
    localparam logic [2:0] SEL_IRQ    = 3'd4;

    typedef struct {
        int          at;
        string       tag;
        logic [2:0]  sel;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   edge_cnt = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic sample(input logic [2:0] sel, output logic [31:0] obs);
        if (sel == SEL_IRQ) begin
            obs = {31'd0, IRQ};
        end else begin
            Addr = sel[1:0];
            #1;
            obs = RD;
        end
    endtask

    task automatic push(input int rel, input string tag, input logic [2:0] sel, input logic [31:0] val);
        exp_t e;
        e.at  = edge_cnt + rel;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0 && sb[0].at <= edge_cnt) begin
            e = sb.pop_front();
            sample(e.sel, obs);
            check_val($sformatf("%s@e%0d", e.tag, edge_cnt), obs, e.val);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            edge_cnt++;
            #1;
            drain();
        end
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        Addr = a;
        WD   = d;
        We   = 1'b1;
        @(posedge clk);
        edge_cnt++;
        #1;
        We = 1'b0;
        drain();
    endtask

    task automatic check_all_zero(input string tag);
        logic [31:0] obs;
        for (int a = 0; a < 4; a++) begin
            sample(3'(a), obs);
            check_val($sformatf("%s_rd%0d", tag, a), obs, 32'd0);
        end
        sample(SEL_IRQ, obs);
        check_val({tag, "_irq"}, obs, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        We    = 1'b0;
        Addr  = 2'd0;
        WD    = 32'd0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("rst_hold");
        rst_n = 1'b1;
        tick(1);
        check_all_zero("rst_rel");

        // One-shot, PRESET=5
        do_write(2'd1, 32'd5);
        do_write(2'd0, 32'h9);
        push(2, "os_cnt5", SEL_COUNT, 32'd5);
        push(2, "os_irq_lo", SEL_IRQ, 32'd0);
        push(6, "os_cnt1", SEL_COUNT, 32'd1);
        push(6, "os_irq_lo6", SEL_IRQ, 32'd0);
        push(7, "os_cnt0", SEL_COUNT, 32'd0);
        push(7, "os_irq_hi", SEL_IRQ, 32'd1);
        push(8, "os_ctrl8", SEL_CTRL, 32'h8);
        push(11, "os_irq_hold", SEL_IRQ, 32'd1);
        push(11, "os_cnt_hold", SEL_COUNT, 32'd0);
        tick(11);
        do_write(2'd0, 32'h8);
        push(0, "os_irq_clr", SEL_IRQ, 32'd0);
        push(0, "os_ctrl_clr", SEL_CTRL, 32'h8);
        drain();

        // Masked interrupt
        do_write(2'd1, 32'd2);
        do_write(2'd0, 32'h1);
        push(2, "mk_cnt2", SEL_COUNT, 32'd2);
        push(4, "mk_cnt0", SEL_COUNT, 32'd0);
        push(4, "mk_irq", SEL_IRQ, 32'd0);
        push(5, "mk_ctrl0", SEL_CTRL, 32'd0);
        tick(5);
        do_write(2'd0, 32'h8);
        push(0, "mk_irq_im", SEL_IRQ, 32'd0);
        drain();

        // Disable mid-count, re-enable reloads PRESET
        do_write(2'd1, 32'd10);
        do_write(2'd0, 32'h9);
        push(2, "dis_cnt10", SEL_COUNT, 32'd10);
        push(7, "dis_cnt5", SEL_COUNT, 32'd5);
        tick(7);
        do_write(2'd0, 32'h8);
        push(1, "dis_cnt4", SEL_COUNT, 32'd4);
        push(3, "dis_frozen", SEL_COUNT, 32'd4);
        push(3, "dis_ctrl", SEL_CTRL, 32'h8);
        tick(3);
        do_write(2'd0, 32'h9);
        push(2, "ren_cnt10", SEL_COUNT, 32'd10);
        push(3, "ren_cnt9", SEL_COUNT, 32'd9);
        tick(3);

        // PRESET write, COUNT write and reserved write during CNT
        do_write(2'd1, 32'd9);
        push(1, "pw_cnt7", SEL_COUNT, 32'd7);
        push(1, "pw_preset", SEL_PRESET, 32'd9);
        tick(1);
        do_write(2'd2, 32'h55);
        push(1, "cw_cnt5", SEL_COUNT, 32'd5);
        tick(1);
        do_write(2'd3, 32'hFFFF_FFFF);
        push(1, "rw_cnt3", SEL_COUNT, 32'd3);
        push(1, "rw_rsvd", SEL_RSVD, 32'd0);
        push(1, "rw_ctrl", SEL_CTRL, 32'h9);
        push(1, "rw_preset", SEL_PRESET, 32'd9);
        push(4, "pw_cnt0", SEL_COUNT, 32'd0);
        push(4, "pw_irq", SEL_IRQ, 32'd1);
        push(5, "pw_ctrl8", SEL_CTRL, 32'h8);
        tick(5);
        do_write(2'd0, 32'h9);
        push(0, "nx_irq_clr", SEL_IRQ, 32'd0);
        push(2, "nx_cnt9", SEL_COUNT, 32'd9);
        drain();
        tick(2);

        // Asynchronous reset mid-count
        rst_n = 1'b0;
        #1;
        check_all_zero("arst");
        tick(3);
        rst_n = 1'b1;
        tick(3);
        check_all_zero("arst_idle");

        // PRESET=0 behaves like PRESET=1
        do_write(2'd1, 32'd0);
        do_write(2'd0, 32'h9);
        push(2, "p0_irq_lo", SEL_IRQ, 32'd0);
        push(3, "p0_irq_hi", SEL_IRQ, 32'd1);
        tick(3);
        do_write(2'd0, 32'h0);
        push(0, "p0_irq_clr", SEL_IRQ, 32'd0);
        drain();

        // Mode 1 request
        do_write(2'd1, 32'd3);
        do_write(2'd0, 32'hB);
`ifdef TIMER_DEV_AUTORELOAD_EN
        begin
            logic [31:0] cnt_tab [0:9];
            logic [31:0] irq_tab [0:9];
            cnt_tab = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd0, 32'd3, 32'd2, 32'd1, 32'd0, 32'd0};
            irq_tab = '{32'd0, 32'd0, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd0};
            push(1, "ar_ctrl", SEL_CTRL, 32'hB);
            for (int k = 0; k < 10; k++) begin
                push(k + 2, "ar_cnt", SEL_COUNT, cnt_tab[k]);
                push(k + 2, "ar_irq", SEL_IRQ, irq_tab[k]);
            end
            push(12, "ar_cnt_wrap", SEL_COUNT, 32'd3);
            tick(12);
        end
`else
        push(1, "mo_ctrl9", SEL_CTRL, 32'h9);
        push(2, "mo_cnt3", SEL_COUNT, 32'd3);
        push(5, "mo_cnt0", SEL_COUNT, 32'd0);
        push(5, "mo_irq_hi", SEL_IRQ, 32'd1);
        push(6, "mo_ctrl8", SEL_CTRL, 32'h8);
        push(10, "mo_irq_hold", SEL_IRQ, 32'd1);
        push(10, "mo_no_reload", SEL_COUNT, 32'd0);
        tick(10);
`endif
        do_write(2'd0, 32'h0);

        check_val("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
